fir_pipelined: RTL and testbench



---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_adder_tree.sv | 46 ++++
 rtl/fir_pipelined.sv | 56 +++++
 tb/tb_fir_pipelined.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the 16-tap fixed-coefficient low-pass FIR.
// Holds datapath widths, tap count, pipeline latency and the coefficient set.
// The coefficients are symmetric, Q15-scaled, and are applied as plain integers.
package fir_pkg;

  localparam int DATA_W  = 16;
  localparam int COEF_W  = 16;
  localparam int OUT_W   = 32;
  localparam int TAPS    = 16;
  localparam int LATENCY = 5;

  localparam logic signed [COEF_W-1:0] COEFS [0:TAPS-1] = '{
    -16'sd120, -16'sd250,  16'sd0,    16'sd900,
     16'sd2300, 16'sd4100, 16'sd5800, 16'sd6800,
     16'sd6800, 16'sd5800, 16'sd4100, 16'sd2300,
     16'sd900,  16'sd0,   -16'sd250, -16'sd120
  };

endpackage

// File: rtl/fir_adder_tree.sv
// Registered 16-input pipelined sum tree (16 -> 8 -> 4 -> 2 -> 1).
// Every level is a register, so latency from i_terms to o_sum is 4 edges.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-high, clears every level
//   i_terms 16 signed W-bit terms, term k at bits [k*W +: W]
//   o_sum   signed W-bit registered sum
// Width does not grow between levels: the caller guarantees the total fits in W.
module fir_adder_tree #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [16*W-1:0]     i_terms,
  output logic signed [W-1:0] o_sum
);

  logic signed [W-1:0] w_terms [0:15];
  logic signed [W-1:0] r_l1    [0:7];
  logic signed [W-1:0] r_l2    [0:3];
  logic signed [W-1:0] r_l3    [0:1];
  logic signed [W-1:0] r_sum;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_terms[i] = i_terms[i*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_l1[i] <= '0;
      for (int i = 0; i < 4; i++) r_l2[i] <= '0;
      for (int i = 0; i < 2; i++) r_l3[i] <= '0;
      r_sum <= '0;
    end else begin
      for (int i = 0; i < 8; i++) r_l1[i] <= w_terms[2*i] + w_terms[2*i+1];
      for (int i = 0; i < 4; i++) r_l2[i] <= r_l1[2*i] + r_l1[2*i+1];
      for (int i = 0; i < 2; i++) r_l3[i] <= r_l2[2*i] + r_l2[2*i+1];
      r_sum <= r_l3[0] + r_l3[1];
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/fir_pipelined.sv
// 16-tap direct-form FIR low-pass filter, one sample in and one result out per clock.
// Pipeline: delay line -> registered products -> 4-level registered adder tree.
// data_out is the response to the sample captured 5 edges earlier.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high, flushes the whole pipeline
//   data_in  signed DATA_W sample, captured every edge
//   data_out signed OUT_W full-precision result, registered
// Worst-case |y| is 32768 * 40540, below 2^31, so no saturation is needed.
module fir_pipelined
  import fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_in,
  output logic signed [OUT_W-1:0]  data_out
);

  logic signed [DATA_W-1:0] r_x [0:TAPS-1];
  logic signed [OUT_W-1:0]  r_p [0:TAPS-1];
  logic [TAPS*OUT_W-1:0]    w_terms;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_p[k] <= '0;
      end
    end else begin
      r_x[0] <= data_in;
      for (int k = 1; k < TAPS; k++) begin
        r_x[k] <= r_x[k-1];
      end
      // Both operands are sign-extended to OUT_W first so the product is exact.
      for (int k = 0; k < TAPS; k++) begin
        r_p[k] <= OUT_W'(r_x[k]) * OUT_W'(COEFS[k]);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      w_terms[k*OUT_W +: OUT_W] = r_p[k];
    end
  end

  fir_adder_tree #(
    .W (OUT_W)
  ) u_tree (
    .clk     (clk),
    .reset   (reset),
    .i_terms (w_terms),
    .o_sum   (data_out)
  );

endmodule

// File: tb/tb_fir_pipelined.sv
module tb_fir_pipelined;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] data_in;
  logic signed [31:0] data_out;

  int checks   = 0;
  int failures = 0;

  int h [16] = '{-120, -250, 0, 900, 2300, 4100, 5800, 6800,
                 6800, 5800, 4100, 2300, 900, 0, -250, -120};
  int hist [16];
  int sb_q [$];

  typedef struct {
    int amp;
    int tap;
    int exp;
  } imp_vec_t;

  imp_vec_t vecs [8];
  int ramp_exp [4] = '{-120000, -370000, -370000, 530000};

  always #5 clk = ~clk;

  fir_pipelined dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: data_out=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Drive one sample (or a reset cycle), update the golden convolution model,
  // then compare the DUT output against the result queued LATENCY samples ago.
  task automatic step(input int d, input bit rst);
    longint acc;
    int     exp_v;
    @(negedge clk);
    data_in = 16'(d);
    reset   = rst;
    if (rst) begin
      foreach (hist[k]) hist[k] = 0;
      foreach (sb_q[i]) sb_q[i] = 0;
      sb_q.push_back(0);
    end else begin
      for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = d;
      acc = 0;
      for (int k = 0; k < 16; k++) acc += longint'(h[k]) * longint'(hist[k]);
      sb_q.push_back(int'(acc));
    end
    @(posedge clk);
    #1;
    if (sb_q.size() > 5) begin
      exp_v = sb_q.pop_front();
      check("scoreboard", data_out, exp_v);
    end
  endtask

  initial begin
    int d;
    int n;
    int e;

    vecs[0] = '{1,      0,  -120};
    vecs[1] = '{1,      7,  6800};
    vecs[2] = '{1,      15, -120};
    vecs[3] = '{-32768, 7,  -222822400};
    vecs[4] = '{-32768, 0,  3932160};
    vecs[5] = '{32767,  8,  222815600};
    vecs[6] = '{-1,     1,  250};
    vecs[7] = '{1000,   13, 0};

    reset   = 1'b1;
    data_in = '0;
    foreach (hist[k]) hist[k] = 0;

    step(0, 1'b1);
    check("reset_state", data_out, 0);
    step(0, 1'b1);
    check("reset_hold", data_out, 0);

    // Impulse table: one nonzero sample, then zeros; tap k shows up 5+k edges later.
    for (int v = 0; v < 8; v++) begin
      step(0, 1'b1);
      for (int j = 0; j <= 21; j++) begin
        step((j == 0) ? vecs[v].amp : 0, 1'b0);
        if (j == 5 + vecs[v].tap)
          check($sformatf("impulse_amp%0d_tap%0d", vecs[v].amp, vecs[v].tap),
                data_out, vecs[v].exp);
      end
    end

    // Step of 1000 held until settled.
    step(0, 1'b1);
    for (int j = 0; j <= 24; j++) begin
      step(1000, 1'b0);
      if (j >= 5 && j <= 8) check($sformatf("step_ramp%0d", j - 5), data_out, ramp_exp[j-5]);
      if (j == 20) check("step_settled", data_out, 39060000);
      if (j == 24) check("step_hold", data_out, 39060000);
    end

    // Step with a one-cycle reset at output 8, then re-ramp from scratch.
    step(0, 1'b1);
    for (int j = 0; j <= 13; j++) step(1000, 1'b0);
    step(1000, 1'b1);
    check("midreset_zero", data_out, 0);
    for (int j = 0; j <= 21; j++) begin
      step(1000, 1'b0);
      if (j < 5) check("midreset_flush", data_out, 0);
      if (j == 5) check("midreset_ramp0", data_out, -120000);
      if (j == 6) check("midreset_ramp1", data_out, -370000);
      if (j == 20) check("midreset_settled", data_out, 39060000);
    end

    // Worst case: every product positive, full-scale magnitude.
    step(0, 1'b1);
    for (int j = 0; j <= 21; j++) begin
      d = 0;
      if (j < 16) d = (h[15-j] < 0) ? -32768 : 32767;
      step(d, 1'b0);
      if (j == 20) check("worst_case", data_out, 1328374920);
    end

    // Linearity: 1 at t=0 plus 3 at t=4.
    step(0, 1'b1);
    for (int j = 0; j <= 30; j++) begin
      step((j == 0) ? 1 : ((j == 4) ? 3 : 0), 1'b0);
      if (j >= 5 && j <= 26) begin
        n = j - 5;
        e = 0;
        if (n < 16) e += h[n];
        if (n >= 4 && n - 4 < 16) e += 3 * h[n-4];
        check($sformatf("linearity_n%0d", n), data_out, e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
